q16_16_mul: RTL and testbench
=============================

# q16_16_mul

Sequential signed Q16.16 fixed-point multiplier for the renderer math path. It is the companion to the Q16.16 divider and uses the same start/done handshake, so the transform and projection stages can schedule either unit in the same way. It retires one multiplier bit per cycle using shift-add on magnitudes, then rounds, applies the sign, and saturates.

## Interface
- `SATURATE`, default 1: 1 clamps an out-of-range result to Q_MAX/Q_MIN; 0 wraps to the low 32 bits of the two's-complement result.
- `ROUND`, default 1: 1 rounds half away from zero using bit 15 of the magnitude; 0 truncates the magnitude.
- `i_clk`, in, 1: clock. Rising edge.
- `i_rst`, in, 1: reset. Asynchronous, active-high.
- `i_start`, in, 1: request an operation. Sampled only in IDLE.
- `i_multiplicand`, in, 32 signed: operand A in Q16.16.
- `i_multiplier`, in, 32 signed: operand B in Q16.16.
- `o_product`, out, 32 signed: A×B in Q16.16. Holds its value until the next FINISH.
- `o_overflow`, out, 1: the result exceeded the Q16.16 range. Updated and held together with `o_product`.
- `o_done`, out, 1: single-cycle pulse marking `o_product` valid.
- `o_busy`, out, 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, MULTIPLY, FINISH.
- IDLE with `i_start`=1:
  - Latch sign = A[31]^B[31].
  - Latch unsigned 32-bit magnitudes |A| and |B|. 0x80000000 maps to magnitude 0x80000000.
  - Clear the 64-bit accumulator, load count=32, go to MULTIPLY.
- After acceptance, operand inputs are don't-care.
- MULTIPLY, one step per cycle:
  - If mag_B[0]=1, acc += mag_A shifted left by (32−count).
  - Shift mag_B right by 1 and decrement count.
  - When count reaches 0, go to FINISH.
- FINISH:
  - mag = acc[63:16] + (ROUND ? acc[15] : 0), a 49-bit value.
  - Overflow when mag > 0x7FFFFFFF with sign=0, or mag > 0x80000000 with sign=1.
  - If there is no overflow, the result is sign ? −mag : mag, truncated to 32 bits.
  - If there is overflow and SATURATE=1, the result is 0x7FFFFFFF (sign=0) or 0x80000000 (sign=1).
  - If there is overflow and SATURATE=0, the result is the low 32 bits of the signed result.
  - Register `o_product` and `o_overflow`, pulse `o_done`, go to IDLE.
- A zero operand is valid: result 0, no overflow, normal latency.

## Timing
- Reset values: state IDLE, `o_product`=0, `o_overflow`=0, `o_done`=0, `o_busy`=0. Accumulator and count are cleared.
- `i_start` sampled high at edge T:
  - MULTIPLY occupies edges T+1 through T+32.
  - FINISH registers the result at edge T+33.
  - `o_done` is high for exactly the cycle after edge T+33.
- Latency is 33 cycles from the start edge.
- `o_busy` rises at edge T and falls at edge T+33, the same edge where `o_done` rises.
- The next `i_start` is accepted at edge T+33 at the earliest, giving an issue interval of 33 cycles. A start held high through the done cycle begins a new operation.
- `i_start` while busy is ignored. It is neither queued nor allowed to corrupt the operation in progress.
- `i_rst` mid-operation aborts immediately: no `o_done`, outputs return to reset values, and the next start behaves normally.
- `o_done` never asserts twice for one start.

## Structure
- Shared package `q16_16_pkg` contains:
  - Q_WIDTH=32, Q_FRAC=16.
  - Q_ONE=32'h0001_0000, Q_MAX=32'h7FFF_FFFF, Q_MIN=32'h8000_0000.
  - The state encoding. The divider should migrate to it.
- Sub-module `q16_16_round_sat` is combinational. It takes the 49-bit magnitude, sign and parameters, and returns the result and overflow. It is used in FINISH and reusable by the divider.
- Everything else lives in one module: FSM, 64-bit accumulator, 6-bit counter, magnitude registers.

## Test plan
- 0x00018000 × 0x00020000 (1.5×2.0) → `o_product`=0x00030000, `o_overflow`=0. `o_done` pulses exactly 33 cycles after the start edge; `o_busy` is high over edges T through T+32 and low again from edge T+33.
- 0xFFFE8000 × 0x00020000 (−1.5×2.0) → 0xFFFD0000. 0x80000000 × 0x00010000 → 0x80000000, overflow 0. 0 × 0x7FFFFFFF → 0.
- Rounding, 0x00000001 × 0x00008000:
  - ROUND=1 → 0x00000001; ROUND=0 → 0x00000000.
  - Negated (0xFFFFFFFF × 0x00008000) with ROUND=1 → 0xFFFFFFFF.
- Overflow, 0x01000000 × 0x01000000:
  - SATURATE=1 → 0x7FFFFFFF with `o_overflow`=1.
  - 0xFF000000 × 0x01000000 → 0x80000000 with overflow 1.
  - 0xFF800000 × 0x01000000 (−128×256) → 0x80000000 with overflow 0.
  - SATURATE=0 with 0x01000000 × 0x01000000 → 0x00000000 with overflow 1.
- Pulse `i_start` with new operands 5 cycles into an operation → ignored; the original result is unaffected. Hold `i_start` high continuously → a new operation issues every 33 cycles, each with a single `o_done`.
- Assert `i_rst` asynchronously at cycle 10 of an operation → outputs go to 0 immediately and no `o_done` follows. Then 0x00030000 × 0x00030000 → 0x00090000.

Source files
------------

// File: rtl/q16_16_pkg.sv
// Shared Q16.16 constants, FSM encoding and helpers for the sequential
// multiplier and divider.
package q16_16_pkg;

    localparam int          Q_WIDTH = 32;
    localparam int          Q_FRAC  = 16;
    localparam logic [31:0] Q_ONE   = 32'h0001_0000;
    localparam logic [31:0] Q_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MULTIPLY = 2'd1,
        ST_FINISH   = 2'd2
    } q_state_t;

    // Unsigned magnitude; 0x80000000 naturally maps to 0x80000000.
    function automatic logic [31:0] q_abs(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/q16_16_round_sat.sv
// Combinational sign application, range check and optional saturation of a
// rounded 49-bit magnitude into a Q16.16 word.
module q16_16_round_sat
    import q16_16_pkg::*;
#(
    parameter logic SATURATE = 1'b1
) (
    input  logic [48:0]        i_mag,
    input  logic               i_sign,
    output logic [Q_WIDTH-1:0] o_result,
    output logic               o_overflow
);

    logic [48:0] w_signed;
    logic        w_unused_hi;

    assign w_signed    = i_sign ? (~i_mag + 49'd1) : i_mag;
    assign w_unused_hi = ^w_signed[48:32];

    // The negative range reaches one step further than the positive one.
    assign o_overflow = i_sign ? (i_mag > 49'h0_8000_0000)
                               : (i_mag > 49'h0_7FFF_FFFF);

    always_comb begin
        o_result = w_signed[31:0];
        if (o_overflow && SATURATE) begin
            o_result = i_sign ? Q_MIN : Q_MAX;
        end
    end

endmodule

// File: rtl/q16_16_mul.sv
// Sequential signed Q16.16 multiplier: one multiplier bit per cycle on
// magnitudes, then round, re-sign and saturate. Start/done handshake.
module q16_16_mul
    import q16_16_pkg::*;
#(
    parameter logic SATURATE = 1'b1,
    parameter logic ROUND    = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [Q_WIDTH-1:0] i_multiplicand,
    input  logic [Q_WIDTH-1:0] i_multiplier,
    output logic [Q_WIDTH-1:0] o_product,
    output logic               o_overflow,
    output logic               o_done,
    output logic               o_busy
);

    q_state_t     r_state;
    q_state_t     w_next;
    logic         r_sign;
    logic [31:0]  r_mag_a;
    logic [31:0]  r_mag_b;
    logic [63:0]  r_acc;
    logic [5:0]   r_count;
    logic [31:0]  r_product;
    logic         r_overflow;
    logic         r_done;

    logic         w_accept;
    logic [5:0]   w_shamt;
    logic [63:0]  w_addend;
    logic [48:0]  w_mag;
    logic [31:0]  w_result;
    logic         w_ovf;
    logic         w_unused_acc;

    // FINISH also samples i_start so back-to-back issue runs every 33 cycles.
    assign w_accept = i_start && (r_state == ST_IDLE || r_state == ST_FINISH);
    assign w_shamt  = 6'd32 - r_count;
    assign w_addend = {32'd0, r_mag_a} << w_shamt;
    assign w_mag    = {1'b0, r_acc[63:16]} + {48'd0, (ROUND ? r_acc[15] : 1'b0)};
    assign w_unused_acc = ^r_acc[14:0];

    q16_16_round_sat #(
        .SATURATE (SATURATE)
    ) u_round_sat (
        .i_mag      (w_mag),
        .i_sign     (r_sign),
        .o_result   (w_result),
        .o_overflow (w_ovf)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (i_start) w_next = ST_MULTIPLY;
            ST_MULTIPLY: if (r_count == 6'd1) w_next = ST_FINISH;
            ST_FINISH:   w_next = i_start ? ST_MULTIPLY : ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sign     <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_product  <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_FINISH) begin
                r_product  <= w_result;
                r_overflow <= w_ovf;
                r_done     <= 1'b1;
            end
            if (w_accept) begin
                r_sign  <= i_multiplicand[31] ^ i_multiplier[31];
                r_mag_a <= q_abs(i_multiplicand);
                r_mag_b <= q_abs(i_multiplier);
                r_acc   <= '0;
                r_count <= 6'd32;
            end else if (r_state == ST_MULTIPLY) begin
                if (r_mag_b[0]) begin
                    r_acc <= r_acc + w_addend;
                end
                r_mag_b <= r_mag_b >> 1;
                r_count <= r_count - 6'd1;
            end
        end
    end

    assign o_product  = r_product;
    assign o_overflow = r_overflow;
    assign o_done     = r_done;

endmodule

// File: tb/tb_q16_16_mul.sv
// Randomized and directed bench for q16_16_mul across three parameter sets,
// checked against an integer-arithmetic reference model.
module tb_q16_16_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;

    logic [31:0] p_d, p_t, p_w;
    logic        ov_d, ov_t, ov_w;
    logic        dn_d, dn_t, dn_w;
    logic        bz_d, bz_t, bz_w;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    q16_16_mul #(.SATURATE(1'b1), .ROUND(1'b1)) u_dflt (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_multiplicand(opa), .i_multiplier(opb),
        .o_product(p_d), .o_overflow(ov_d), .o_done(dn_d), .o_busy(bz_d));

    q16_16_mul #(.SATURATE(1'b1), .ROUND(1'b0)) u_trunc (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_multiplicand(opa), .i_multiplier(opb),
        .o_product(p_t), .o_overflow(ov_t), .o_done(dn_t), .o_busy(bz_t));

    q16_16_mul #(.SATURATE(1'b0), .ROUND(1'b1)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_multiplicand(opa), .i_multiplier(opb),
        .o_product(p_w), .o_overflow(ov_w), .o_done(dn_w), .o_busy(bz_w));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact product of the real values, scaled back by 2^16 with the
    // configured rounding, then range-checked.
    function automatic void ref_mul(input logic [31:0] ma, input logic [31:0] mb,
                                    input bit sat, input bit rnd,
                                    output logic [31:0] prod, output logic ovf);
        longint sa, sb, mag, q, r;
        bit     neg;
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        mag = sa * sb;
        neg = ma[31] ^ mb[31];
        if (mag < 0) mag = -mag;
        q = mag / 65536;
        if (rnd && (mag % 65536) >= 32768) q = q + 1;
        ovf = neg ? (q > 64'sh8000_0000) : (q > 64'sh7FFF_FFFF);
        if (ovf && sat) begin
            prod = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            r    = neg ? -q : q;
            prod = r[31:0];
        end
    endfunction

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
        @(posedge clk); #1;
        opa = ia; opb = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        opa = $urandom; opb = $urandom;
        check("busy_rise", {31'd0, bz_d}, 32'd1);
    endtask

    task automatic wait_done(input int lat0, output int lat, output int busy_gaps);
        lat = lat0;
        busy_gaps = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!dn_d && !bz_d) busy_gaps++;
        end while (!dn_d && lat < 45);
    endtask

    task automatic op_check(input string tag, input logic [31:0] ia, input logic [31:0] ib);
        logic [31:0] ed, et, ew;
        logic        od, ot, ow;
        int          lat, gaps;
        ref_mul(ia, ib, 1'b1, 1'b1, ed, od);
        ref_mul(ia, ib, 1'b1, 1'b0, et, ot);
        ref_mul(ia, ib, 1'b0, 1'b1, ew, ow);
        issue(ia, ib);
        wait_done(0, lat, gaps);
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_busy_gap"}, 32'(gaps), 32'd0);
        check({tag, "_busy_fall"}, {31'd0, bz_d}, 32'd0);
        check({tag, "_prod_dflt"}, p_d, ed);
        check({tag, "_ovf_dflt"}, {31'd0, ov_d}, {31'd0, od});
        check({tag, "_prod_trunc"}, p_t, et);
        check({tag, "_ovf_trunc"}, {31'd0, ov_t}, {31'd0, ot});
        check({tag, "_prod_wrap"}, p_w, ew);
        check({tag, "_ovf_wrap"}, {31'd0, ov_w}, {31'd0, ow});
        check({tag, "_done_all"}, {30'd0, dn_t, dn_w}, 32'd3);
        @(posedge clk); #1;
        check({tag, "_done_single"}, {29'd0, dn_d, dn_t, dn_w}, 32'd0);
    endtask

    logic [31:0] da [9] = '{32'h0001_8000, 32'hFFFE_8000, 32'h8000_0000, 32'h0000_0000,
                            32'h0000_0001, 32'hFFFF_FFFF, 32'h0100_0000, 32'hFF00_0000,
                            32'hFF80_0000};
    logic [31:0] db [9] = '{32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 32'h7FFF_FFFF,
                            32'h0000_8000, 32'h0000_8000, 32'h0100_0000, 32'h0100_0000,
                            32'h0100_0000};
    logic [31:0] dexp [9] = '{32'h0003_0000, 32'hFFFD_0000, 32'h8000_0000, 32'h0000_0000,
                              32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                              32'h8000_0000};
    logic        dovf [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        logic [31:0] ra, rb, ea, eb, ce[3];
        logic        co;
        logic [31:0] ca[3], cb[3];
        int          lat, gaps, ndone;

        // Reset state
        #1;
        check("rst_prod", p_d, 32'd0);
        check("rst_flags", {29'd0, ov_d, dn_d, bz_d}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Directed cases with hand-derived results
        for (int i = 0; i < 9; i++) begin
            op_check($sformatf("dir%0d", i), da[i], db[i]);
            check($sformatf("dir%0d_const", i), p_d, dexp[i]);
            check($sformatf("dir%0d_const_ovf", i), {31'd0, ov_d}, {31'd0, dovf[i]});
        end
        op_check("rnd", 32'h0000_0001, 32'h0000_8000);
        check("trunc_const", p_t, 32'h0000_0000);
        op_check("wrap", 32'h0100_0000, 32'h0100_0000);
        check("wrap_const", p_w, 32'h0000_0000);
        check("wrap_const_ovf", {31'd0, ov_w}, 32'd1);

        // Randomized operands, varied magnitudes
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            ra = $signed(ra) >>> $urandom_range(0, 20);
            rb = $signed(rb) >>> $urandom_range(0, 20);
            op_check($sformatf("rand%0d", i), ra, rb);
        end

        // Start pulse while busy must be ignored
        ref_mul(32'h0005_0000, 32'h0002_4000, 1'b1, 1'b1, ea, co);
        issue(32'h0005_0000, 32'h0002_4000);
        repeat (4) @(posedge clk);
        #1;
        opa = 32'h7FFF_0000; opb = 32'h7FFF_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5, lat, gaps);
        check("ignore_latency", 32'(lat), 32'd33);
        check("ignore_prod", p_d, ea);
        check("ignore_prod_const", p_d, 32'h000B_4000);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (dn_d) ndone++;
        end
        check("ignore_no_extra_done", 32'(ndone), 32'd0);
        check("ignore_idle", {31'd0, bz_d}, 32'd0);

        // Start held high: one operation every 33 cycles
        ca = '{32'h0002_0000, 32'hFFFF_0000, 32'h0064_0000};
        cb = '{32'h0003_0000, 32'h0000_8000, 32'hFFFE_0000};
        for (int k = 0; k < 3; k++) ref_mul(ca[k], cb[k], 1'b1, 1'b1, ce[k], co);
        @(posedge clk); #1;
        opa = ca[0]; opb = cb[0]; start = 1'b1;
        @(posedge clk); #1;
        opa = ca[1]; opb = cb[1];
        ndone = 0;
        for (int c = 1; c <= 99; c++) begin
            @(posedge clk); #1;
            if (dn_d) ndone++;
            if (c % 33 == 0) begin
                check($sformatf("cont_done%0d", c / 33), {31'd0, dn_d}, 32'd1);
                check($sformatf("cont_prod%0d", c / 33), p_d, ce[c / 33 - 1]);
                if (c == 33) begin
                    opa = ca[2]; opb = cb[2];
                end
            end
            if (c == 98) start = 1'b0;
        end
        check("cont_done_count", 32'(ndone), 32'd3);
        check("cont_idle", {31'd0, bz_d}, 32'd0);

        // Asynchronous reset mid-operation
        issue(32'h0007_0000, 32'h0003_0000);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_prod", p_d, 32'd0);
        check("arst_flags", {29'd0, ov_d, dn_d, bz_d}, 32'd0);
        #4 rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (dn_d || bz_d) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        op_check("after_rst", 32'h0003_0000, 32'h0003_0000);
        check("after_rst_const", p_d, 32'h0009_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
